fwd_ctrl: RTL
=============

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_id_valid, input, 1, decode-stage instruction present.
REQ-005 SHALL have port i_id_rs1, input, REG_W, decode-stage source 1 index.
REQ-006 SHALL have port i_id_rs2, input, REG_W, decode-stage source 2 index.
REQ-007 SHALL have port i_id_rd, input, REG_W, decode-stage destination index.
REQ-008 SHALL have port i_id_regwr, input, 1, decode-stage instruction writes rd.
REQ-009 SHALL have port i_id_memrd, input, 1, decode-stage instruction is a load.
REQ-010 SHALL have port i_flush, input, 1, squash the instruction entering EX (taken branch/jump).
REQ-011 SHALL have port o_fwd_a_sel, output, 2, select for the EX operand-A 3:1 mux.
REQ-012 SHALL have port o_fwd_b_sel, output, 2, select for the EX operand-B 3:1 mux.
REQ-013 SHALL have port o_stall, output, 1, hold PC and IF/ID register one cycle (load-use).
REQ-014 SHALL have port o_wb_rd, output, REG_W, plus o_wb_regwr, output, 1, writeback-stage destination and write enable.

Function
REQ-015 SHALL track three internal stages EX, MEM, WB, each holding {valid, rs1, rs2, rd, regwr, memrd}; MEM and WB use only valid/rd/regwr/memrd.
REQ-016 SHALL advance every cycle: WB<=MEM, MEM<=EX, EX<=ID fields; latency from ID capture to WB visibility is 3 cycles.
REQ-017 SHALL load EX with a bubble (valid=0, regwr=0, memrd=0, indices 0) when i_flush=1, o_stall=1, or i_id_valid=0.
REQ-018 SHALL encode selects as 2'b00 register file, 2'b01 EX/MEM result, 2'b10 MEM/WB result; 2'b11 SHALL never be driven.
REQ-019 SHALL drive o_fwd_a_sel=2'b01 when MEM.valid, MEM.regwr, MEM.rd!=0, MEM.rd==EX.rs1; else 2'b10 when the same holds for WB; else 2'b00 (same rule for B with EX.rs2).
REQ-020 SHALL give MEM priority over WB when both match (youngest producer wins).
REQ-021 SHALL never forward for index 0 (x0 hardwired zero).
REQ-022 SHALL compute selects combinationally from registered stage state only (no ID-input path).
REQ-023 SHALL assert o_stall when EX.valid, EX.memrd, EX.rd!=0, i_id_valid, and EX.rd equals i_id_rs1 or i_id_rs2; otherwise 0.
REQ-024 SHALL gate o_stall with i_flush: flush and stall together -> o_stall=0, EX bubble, flush wins.
REQ-025 SHALL deassert o_stall after exactly one cycle for a single load-use pair, since the load moves to MEM and the bubble enters EX.
REQ-026 SHALL drive o_wb_rd=WB.rd and o_wb_regwr=WB.valid&WB.regwr.

Reset
REQ-027 SHALL, when i_rst=1 at a rising edge, clear all three stages to bubbles regardless of other inputs, including mid-stall or mid-flush.
REQ-028 SHALL present after reset: o_fwd_a_sel=2'b00, o_fwd_b_sel=2'b00, o_stall=0 (absent a load in EX), o_wb_rd=0, o_wb_regwr=0.

Structure
REQ-029 SHALL place the fwd_sel enum (FWD_RF, FWD_MEM, FWD_WB) and the stage struct typedef in a shared package, fwd_pkg.
REQ-030 SHALL implement each stage register as one sub-module, fwd_stage_reg (sync reset, bubble-load input), instantiated three times.
REQ-031 SHALL produce selects whose encoding matches the existing 32-bit mux3_1 sel input bit-for-bit.

Verification
REQ-032 SHALL cover: add x5 then add x6,x5,x1 back-to-back -> cycle the consumer is in EX, o_fwd_a_sel=2'b01.
REQ-033 SHALL cover: add x5, nop, sub x7,x2,x5 -> o_fwd_b_sel=2'b10 when sub in EX.
REQ-034 SHALL cover: x5 written by both MEM and WB instructions, consumer reads x5 -> select 2'b01.
REQ-035 SHALL cover: lw x8 then add x9,x8,x8 -> o_stall=1 exactly one cycle, then o_fwd_a_sel=o_fwd_b_sel=2'b10.
REQ-036 SHALL cover: producer writes x0, consumer reads x0 -> selects stay 2'b00, no stall; and lw hazard with i_flush=1 -> o_stall=0, EX bubble.
REQ-037 SHALL cover: i_rst pulsed during a stall -> next cycle all outputs at reset values and o_wb_regwr=0 for 3 cycles.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding / load-use hazard controller:
// the 3:1 operand-mux select encoding and the per-stage pipeline record.
package fwd_pkg;

    // Widest register index the stage record can hold; narrower REG_W values
    // are zero-extended into it so index compares stay exact.
    localparam int FWD_IDX_W = 8;

    typedef logic [FWD_IDX_W-1:0] fwd_idx_t;

    // Encoding matches the sel input of the existing 32-bit mux3_1.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic     valid;
        fwd_idx_t rs1;
        fwd_idx_t rs2;
        fwd_idx_t rd;
        logic     regwr;
        logic     memrd;
    } fwd_stage_t;

    localparam fwd_idx_t   FWD_IDX_ZERO = {FWD_IDX_W{1'b0}};
    localparam fwd_stage_t FWD_BUBBLE   = '{
        valid: 1'b0,
        rs1:   {FWD_IDX_W{1'b0}},
        rs2:   {FWD_IDX_W{1'b0}},
        rd:    {FWD_IDX_W{1'b0}},
        regwr: 1'b0,
        memrd: 1'b0
    };

    // A stage can supply a source operand when it holds a live instruction
    // that writes a nonzero register equal to that source.
    function automatic logic fwd_hit(input fwd_stage_t stg, input fwd_idx_t src);
        logic hit;
        if (stg.valid && stg.regwr && (stg.rd != FWD_IDX_ZERO) && (stg.rd == src)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Youngest producer wins: MEM is checked before WB.
    function automatic fwd_sel_e fwd_pick(input fwd_stage_t mem, input fwd_stage_t wb,
                                          input fwd_idx_t src);
        fwd_sel_e sel;
        if (fwd_hit(mem, src)) begin
            sel = FWD_MEM;
        end else if (fwd_hit(wb, src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage record with synchronous reset and a bubble-load input
// that replaces the incoming instruction with an empty slot.
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_bubble,
    input  fwd_stage_t i_d,
    output fwd_stage_t o_q
);

    fwd_stage_t r_q;

    // Stage register: reset and bubble both load an empty slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= FWD_BUBBLE;
        end else if (i_bubble) begin
            r_q <= FWD_BUBBLE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB instruction records, selects operand-mux sources from the
// registered stages and stalls decode for one cycle behind a load.
module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_id_regwr,
    input  logic             i_id_memrd,
    input  logic             i_flush,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_stall,
    output logic [REG_W-1:0] o_wb_rd,
    output logic             o_wb_regwr
);

    fwd_stage_t w_id_stage;
    fwd_stage_t r_ex;
    fwd_stage_t r_mem;
    fwd_stage_t r_wb;
    logic       w_load_use;
    logic       w_stall;
    logic       w_ex_bubble;
    fwd_sel_e   w_a_sel;
    fwd_sel_e   w_b_sel;

    // Pack decode-stage fields into a stage record, zero-extending indices.
    always_comb begin
        w_id_stage                 = FWD_BUBBLE;
        w_id_stage.valid           = i_id_valid;
        w_id_stage.rs1[REG_W-1:0]  = i_id_rs1;
        w_id_stage.rs2[REG_W-1:0]  = i_id_rs2;
        w_id_stage.rd[REG_W-1:0]   = i_id_rd;
        w_id_stage.regwr           = i_id_regwr;
        w_id_stage.memrd           = i_id_memrd;
    end

    // Load in EX whose result a decode-stage source needs: data arrives too late.
    always_comb begin
        w_load_use = 1'b0;
        if (r_ex.valid && r_ex.memrd && (r_ex.rd != FWD_IDX_ZERO) && i_id_valid &&
            ((r_ex.rd == w_id_stage.rs1) || (r_ex.rd == w_id_stage.rs2))) begin
            w_load_use = 1'b1;
        end else begin
            w_load_use = 1'b0;
        end
    end

    // A flush squashes the consumer anyway, so it overrides the stall.
    assign w_stall     = w_load_use & ~i_flush;
    assign w_ex_bubble = i_flush | w_stall | ~i_id_valid;

    fwd_stage_reg u_ex (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_bubble (w_ex_bubble),
        .i_d      (w_id_stage),
        .o_q      (r_ex)
    );

    fwd_stage_reg u_mem (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_bubble (1'b0),
        .i_d      (r_ex),
        .o_q      (r_mem)
    );

    fwd_stage_reg u_wb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_bubble (1'b0),
        .i_d      (r_mem),
        .o_q      (r_wb)
    );

    // Operand selects depend only on registered stage state.
    always_comb begin
        w_a_sel = fwd_pick(r_mem, r_wb, r_ex.rs1);
        w_b_sel = fwd_pick(r_mem, r_wb, r_ex.rs2);
    end

    assign o_fwd_a_sel = w_a_sel;
    assign o_fwd_b_sel = w_b_sel;
    assign o_stall     = w_stall;
    assign o_wb_rd     = r_wb.rd[REG_W-1:0];
    assign o_wb_regwr  = r_wb.valid & r_wb.regwr;

endmodule
